// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and display-enable with
// configurable delay, line/frame pulses, scanline compare interrupt and frame counter.
module video_timing_gen #(
   parameter int unsigned H_VISIBLE       = 640,
   parameter int unsigned H_FRONT_PORCH   = 16,
   parameter int unsigned H_SYNC_PULSE    = 96,
   parameter int unsigned H_BACK_PORCH    = 48,
   parameter int unsigned V_VISIBLE       = 480,
   parameter int unsigned V_FRONT_PORCH   = 10,
   parameter int unsigned V_SYNC_PULSE    = 2,
   parameter int unsigned V_BACK_PORCH    = 33,
   parameter logic        H_SYNC_POLARITY = 1'b0,
   parameter logic        V_SYNC_POLARITY = 1'b0,
   parameter int unsigned SYNC_DELAY      = 0
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        enable_i,
   input  logic [10:0] line_cmp_i,
   input  logic        line_cmp_en_i,
   output logic [10:0] h_count_o,
   output logic [10:0] v_count_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        visible_o,
   output logic        end_of_line_o,
   output logic        end_of_frame_o,
   output logic        line_irq_o,
   output logic [15:0] scanline_o,
   output logic [7:0]  frame_count_o
);

   localparam int unsigned CW       = 11;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT_PORCH;
   localparam int unsigned HS_END   = HS_START + H_SYNC_PULSE;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT_PORCH;
   localparam int unsigned VS_END   = VS_START + V_SYNC_PULSE;
   localparam int unsigned STAGES   = SYNC_DELAY + 1;
   // Pipeline word layout: {hsync, vsync, visible}
   localparam logic [2:0]  IDLE     = {~H_SYNC_POLARITY, ~V_SYNC_POLARITY, 1'b0};

   if (H_TOTAL > 2048 || V_TOTAL > 2048 || SYNC_DELAY > 4) begin : g_bad_cfg
      $error("video_timing_gen: H/V total exceeds 2048 or SYNC_DELAY exceeds 4");
   end

   logic [CW-1:0] h_q, h_d, v_q, v_d;
   logic [7:0]    fc_q, fc_d;
   logic [2:0]    pipe_q [STAGES];
   logic [2:0]    pipe_d [STAGES];
   logic          h_wrap, v_wrap, hs_act, vs_act, vis_act;

   // Counter advance and sync/visible pipeline, all frozen while disabled
   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      fc_d   = fc_q;
      pipe_d = pipe_q;
      h_wrap  = (h_q == CW'(H_TOTAL - 1));
      v_wrap  = (v_q == CW'(V_TOTAL - 1));
      hs_act  = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
      vs_act  = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
      vis_act = (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
      if (enable_i) begin
         h_d = h_wrap ? '0 : h_q + CW'(1);
         if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + CW'(1);
            if (v_wrap) fc_d = fc_q + 8'd1;
         end
         pipe_d[0] = {hs_act ? H_SYNC_POLARITY : ~H_SYNC_POLARITY,
                      vs_act ? V_SYNC_POLARITY : ~V_SYNC_POLARITY,
                      vis_act};
         for (int unsigned i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         h_q  <= '0;
         v_q  <= '0;
         fc_q <= '0;
         for (int unsigned i = 0; i < STAGES; i++) pipe_q[i] <= IDLE;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         fc_q   <= fc_d;
         pipe_q <= pipe_d;
      end
   end

   assign h_count_o     = h_q;
   assign v_count_o     = v_q;
   assign frame_count_o = fc_q;
   assign hsync_o       = pipe_q[STAGES-1][2];
   assign vsync_o       = pipe_q[STAGES-1][1];
   assign visible_o     = pipe_q[STAGES-1][0];

   // Pulses decode the live counters so they line up with h_count_o, no delay
   assign end_of_line_o  = enable_i & h_wrap;
   assign end_of_frame_o = enable_i & h_wrap & v_wrap;
   assign line_irq_o     = enable_i & line_cmp_en_i & (h_q == CW'(H_VISIBLE)) & (v_q == line_cmp_i);
   assign scanline_o     = {32'(v_q) >= V_VISIBLE, 32'(h_q) >= H_VISIBLE, 3'b000, v_q};

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default, delayed sync, small raster)
// compared every half cycle against a counter model with a per-instance sync queue.
module tb_video_timing_gen;

   localparam int unsigned P_HV [3] = '{640, 640, 8};
   localparam int unsigned P_HF [3] = '{16, 16, 2};
   localparam int unsigned P_HS [3] = '{96, 96, 3};
   localparam int unsigned P_HB [3] = '{48, 48, 2};
   localparam int unsigned P_VV [3] = '{480, 480, 6};
   localparam int unsigned P_VF [3] = '{10, 10, 1};
   localparam int unsigned P_VS [3] = '{2, 2, 2};
   localparam int unsigned P_VB [3] = '{33, 33, 3};
   localparam bit          P_HP [3] = '{1'b0, 1'b0, 1'b1};
   localparam bit          P_VP [3] = '{1'b0, 1'b0, 1'b1};
   localparam int unsigned P_D  [3] = '{0, 3, 1};

   logic        clk = 1'b0;
   logic        reset_n_i, enable_i, line_cmp_en_i;
   logic [10:0] line_cmp_i;
   logic [10:0] hc [3];
   logic [10:0] vc [3];
   logic        hs [3], vs [3], vis [3], eol [3], eof [3], irq [3];
   logic [15:0] sc [3];
   logic [7:0]  fc [3];

   int unsigned n_checks = 0, n_errors = 0;
   int unsigned h_m [3], v_m [3], fc_m [3];
   logic [2:0]  q0[$], q1[$], q2[$];
   int unsigned cyc;
   int unsigned cnt_eol [3], cnt_eof [3], cnt_irq [3], cnt_hs [3], cnt_vs [3];
   int          first_hs [3];

   always #5 clk = ~clk;

   video_timing_gen u_def (
      .clk(clk), .reset_n_i(reset_n_i), .enable_i(enable_i), .line_cmp_i(line_cmp_i),
      .line_cmp_en_i(line_cmp_en_i), .h_count_o(hc[0]), .v_count_o(vc[0]), .hsync_o(hs[0]),
      .vsync_o(vs[0]), .visible_o(vis[0]), .end_of_line_o(eol[0]), .end_of_frame_o(eof[0]),
      .line_irq_o(irq[0]), .scanline_o(sc[0]), .frame_count_o(fc[0]));

   video_timing_gen #(.SYNC_DELAY(3)) u_dly (
      .clk(clk), .reset_n_i(reset_n_i), .enable_i(enable_i), .line_cmp_i(line_cmp_i),
      .line_cmp_en_i(line_cmp_en_i), .h_count_o(hc[1]), .v_count_o(vc[1]), .hsync_o(hs[1]),
      .vsync_o(vs[1]), .visible_o(vis[1]), .end_of_line_o(eol[1]), .end_of_frame_o(eof[1]),
      .line_irq_o(irq[1]), .scanline_o(sc[1]), .frame_count_o(fc[1]));

   video_timing_gen #(
      .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
      .V_VISIBLE(6), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
      .H_SYNC_POLARITY(1'b1), .V_SYNC_POLARITY(1'b1), .SYNC_DELAY(1)
   ) u_sml (
      .clk(clk), .reset_n_i(reset_n_i), .enable_i(enable_i), .line_cmp_i(line_cmp_i),
      .line_cmp_en_i(line_cmp_en_i), .h_count_o(hc[2]), .v_count_o(vc[2]), .hsync_o(hs[2]),
      .vsync_o(vs[2]), .visible_o(vis[2]), .end_of_line_o(eol[2]), .end_of_frame_o(eof[2]),
      .line_irq_o(irq[2]), .scanline_o(sc[2]), .frame_count_o(fc[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned ht(input int k);
      return P_HV[k] + P_HF[k] + P_HS[k] + P_HB[k];
   endfunction

   function automatic int unsigned vt(input int k);
      return P_VV[k] + P_VF[k] + P_VS[k] + P_VB[k];
   endfunction

   // Expected {hsync, vsync, visible} for a given counter position
   function automatic logic [2:0] raw_f(input int k, input int unsigned h, input int unsigned v);
      logic hsa, vsa, visa;
      hsa  = (h >= P_HV[k] + P_HF[k]) && (h < P_HV[k] + P_HF[k] + P_HS[k]);
      vsa  = (v >= P_VV[k] + P_VF[k]) && (v < P_VV[k] + P_VF[k] + P_VS[k]);
      visa = (h < P_HV[k]) && (v < P_VV[k]);
      return {hsa ? P_HP[k] : ~P_HP[k], vsa ? P_VP[k] : ~P_VP[k], visa};
   endfunction

   function automatic logic [2:0] q_front(input int k);
      case (k)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic q_push(input int k, input logic [2:0] x, input bit pop);
      case (k)
         0: begin q0.push_back(x); if (pop) void'(q0.pop_front()); end
         1: begin q1.push_back(x); if (pop) void'(q1.pop_front()); end
         default: begin q2.push_back(x); if (pop) void'(q2.pop_front()); end
      endcase
   endtask

   task automatic model_reset();
      q0.delete(); q1.delete(); q2.delete();
      for (int k = 0; k < 3; k++) begin
         h_m[k] = 0; v_m[k] = 0; fc_m[k] = 0;
         for (int i = 0; i <= int'(P_D[k]); i++)
            q_push(k, {~P_HP[k], ~P_VP[k], 1'b0}, 1'b0);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         q_push(k, raw_f(k, h_m[k], v_m[k]), 1'b1);
         if (h_m[k] == ht(k) - 1) begin
            h_m[k] = 0;
            if (v_m[k] == vt(k) - 1) begin
               v_m[k] = 0;
               fc_m[k] = (fc_m[k] + 1) % 256;
            end else v_m[k]++;
         end else h_m[k]++;
      end
   endtask

   task automatic check_all();
      logic [2:0]  s;
      logic        e_eol;
      logic [15:0] e_sc;
      for (int k = 0; k < 3; k++) begin
         s     = q_front(k);
         e_eol = enable_i && (h_m[k] == ht(k) - 1);
         e_sc  = {v_m[k] >= P_VV[k], h_m[k] >= P_HV[k], 3'b000, 11'(v_m[k])};
         chk($sformatf("u%0d.h_count", k), 32'(hc[k]), h_m[k]);
         chk($sformatf("u%0d.v_count", k), 32'(vc[k]), v_m[k]);
         chk($sformatf("u%0d.frame_count", k), 32'(fc[k]), fc_m[k]);
         chk($sformatf("u%0d.hsync", k), 32'(hs[k]), 32'(s[2]));
         chk($sformatf("u%0d.vsync", k), 32'(vs[k]), 32'(s[1]));
         chk($sformatf("u%0d.visible", k), 32'(vis[k]), 32'(s[0]));
         chk($sformatf("u%0d.eol", k), 32'(eol[k]), 32'(e_eol));
         chk($sformatf("u%0d.eof", k), 32'(eof[k]), 32'(e_eol && (v_m[k] == vt(k) - 1)));
         chk($sformatf("u%0d.line_irq", k), 32'(irq[k]),
             32'(enable_i && line_cmp_en_i && h_m[k] == P_HV[k] && v_m[k] == 32'(line_cmp_i)));
         chk($sformatf("u%0d.scanline", k), 32'(sc[k]), 32'(e_sc));
      end
   endtask

   task automatic mon_clear();
      cyc = 0;
      for (int k = 0; k < 3; k++) begin
         cnt_eol[k] = 0; cnt_eof[k] = 0; cnt_irq[k] = 0; cnt_hs[k] = 0; cnt_vs[k] = 0;
         first_hs[k] = -1;
      end
   endtask

   task automatic monitor();
      for (int k = 0; k < 3; k++) begin
         cnt_eol[k] += 32'(eol[k]);
         cnt_eof[k] += 32'(eof[k]);
         cnt_irq[k] += 32'(irq[k]);
         if (vs[k] == P_VP[k]) cnt_vs[k]++;
         if (hs[k] == P_HP[k]) begin
            cnt_hs[k]++;
            if (first_hs[k] < 0) first_hs[k] = int'(cyc);
         end
      end
   endtask

   // One clock: drive at negedge, check, model the posedge, check again
   task automatic cycle(input logic en, input logic rn);
      @(negedge clk);
      enable_i  = en;
      reset_n_i = rn;
      if (!rn) model_reset();
      #1 check_all();
      @(posedge clk);
      if (rn && en) model_step();
      #1;
      cyc++;
      check_all();
      monitor();
   endtask

   initial begin
      reset_n_i = 1'b0; enable_i = 1'b0; line_cmp_en_i = 1'b0; line_cmp_i = 11'd0;
      model_reset();
      mon_clear();
      repeat (3) cycle(1'b0, 1'b0);

      // First line on the default rasters
      mon_clear();
      repeat (800) cycle(1'b1, 1'b1);
      chk("eol_pulses_line", cnt_eol[0], 1);
      chk("hsync_low_cycles", cnt_hs[0], 96);
      chk("hsync_low_cycles_dly", cnt_hs[1], 96);
      chk("hsync_first_low", 32'(first_hs[0]), 657);
      chk("hsync_first_low_dly", 32'(first_hs[1]), 660);
      chk("eol_pulses_line_dly", cnt_eol[1], 1);
      chk("h_after_line", 32'(hc[0]), 0);
      chk("v_after_line", 32'(vc[0]), 1);

      // Stall at h=300
      repeat (300) cycle(1'b1, 1'b1);
      mon_clear();
      repeat (50) cycle(1'b0, 1'b1);
      chk("hold_h", 32'(hc[0]), 300);
      chk("hold_pulses", cnt_eol[0] + cnt_eol[2] + cnt_irq[2], 0);
      repeat (5) cycle(1'b1, 1'b1);

      // Small raster: frames, frame counter, vsync and line compare
      repeat (2) cycle(1'b1, 1'b0);
      line_cmp_i = 11'd4; line_cmp_en_i = 1'b1;
      mon_clear();
      repeat (180) cycle(1'b1, 1'b1);
      chk("frame_count_one", 32'(fc[2]), 1);
      chk("eof_one_frame", cnt_eof[2], 1);
      repeat (180) cycle(1'b1, 1'b1);
      chk("line_irq_two_frames", cnt_irq[2], 2);
      chk("eof_two_frames", cnt_eof[2], 2);
      chk("vsync_active_cycles", cnt_vs[2], 60);
      line_cmp_en_i = 1'b0;
      mon_clear();
      repeat (360) cycle(1'b1, 1'b1);
      chk("line_irq_disabled", cnt_irq[2], 0);
      line_cmp_en_i = 1'b1;
      foreach (P_D[j]) begin
         if (j < 2) begin
            line_cmp_i = (j == 0) ? 11'd600 : 11'd12;
            mon_clear();
            repeat (360) cycle(1'b1, 1'b1);
            chk($sformatf("line_irq_out_of_range_%0d", j), cnt_irq[2], 0);
         end
      end

      // Scanline status around the blank corner of the small raster
      repeat (2) cycle(1'b1, 1'b0);
      repeat (97) cycle(1'b1, 1'b1);
      chk("scanline_h7_v6", 32'(sc[2]), 32'h8006);
      cycle(1'b1, 1'b1);
      chk("scanline_h8_v6", 32'(sc[2]), 32'hC006);

      // Asynchronous reset mid-frame on the default raster
      repeat (4000) cycle(1'b1, 1'b1);
      chk("pre_reset_v", 32'(vc[0]), 5);
      @(posedge clk);
      #3 reset_n_i = 1'b0;
      model_reset();
      #1 check_all();
      chk("async_rst_h", 32'(hc[0]), 0);
      chk("async_rst_v", 32'(vc[0]), 0);
      chk("async_rst_hsync", 32'(hs[0]), 1);
      chk("async_rst_visible", 32'(vis[0]), 0);
      repeat (2) cycle(1'b1, 1'b0);
      mon_clear();
      repeat (20) cycle(1'b1, 1'b1);
      chk("restart_h", 32'(hc[0]), 20);
      chk("restart_v", 32'(vc[0]), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
